// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin select: on a tie the master that did not own the bus last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       id
);

  always_comb begin
    valid = |req;
    id    = 1'b0;
    if (req == 2'b11) begin
      id = ~last;
    end else begin
      id = req[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master Avalon-style bus arbiter; one outstanding transaction, fields captured at grant.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic                grant_id
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0] req;
  logic       pick_valid;
  logic       pick_id;
  logic       sel_wr;

  assign req    = {m1_read | m1_write, m0_read | m0_write};
  // Write has priority when a master raises both strobes.
  assign sel_wr = (pick_id == M_AUX) ? m1_write : m0_write;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_id;
          op_d    = sel_wr ? OP_WRITE : OP_READ;
          rd_d    = ~sel_wr;
          wr_d    = sel_wr;
          if (pick_id == M_AUX) begin
            addr_d  = m1_address;
            wdata_d = m1_writedata;
            be_d    = m1_byteenable;
          end else begin
            addr_d  = m0_address;
            wdata_d = m0_writedata;
            be_d    = m0_byteenable;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!s_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = (op_q == OP_WRITE) ? DONE : RDATA;
        end
      end
      RDATA: begin
        // Slave read data is valid exactly one cycle after acceptance.
        if (grant_q == M_AUX) begin
          rdata1_d = s_readdata;
        end else begin
          rdata0_d = s_readdata;
        end
        state_d = DONE;
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= M_CPU;
      last_q   <= M_AUX;
      op_q     <= OP_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign s_address      = addr_q;
  assign s_read         = rd_q;
  assign s_write        = wr_q;
  assign s_writedata    = wdata_q;
  assign s_byteenable   = be_q;
  assign grant_id       = grant_q;
  assign m0_readdata    = rdata0_q;
  assign m1_readdata    = rdata1_q;
  assign m0_waitrequest = !((state_q == DONE) && (grant_q == M_CPU));
  assign m1_waitrequest = !((state_q == DONE) && (grant_q == M_AUX));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random two-master traffic against a slave memory.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic        grant_id;

  txn_t tx [2];
  int   checks = 0;
  int   errors = 0;
  bit   run;
  int   stall_cfg;
  bit   rand_stall;

  logic [1:0]  wq;
  logic [31:0] rdq [2];
  assign wq     = {m1_waitrequest, m0_waitrequest};
  assign rdq[0] = m0_readdata;
  assign rdq[1] = m1_readdata;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .m0_address     (tx[0].addr),
    .m0_read        (tx[0].rd),
    .m0_write       (tx[0].wr),
    .m0_writedata   (tx[0].data),
    .m0_byteenable  (tx[0].be),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (tx[1].addr),
    .m1_read        (tx[1].rd),
    .m1_write       (tx[1].wr),
    .m1_writedata   (tx[1].data),
    .m1_byteenable  (tx[1].be),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .grant_id       (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_init(input int i);
    return 32'h3C08BFC0 ^ (32'(i) * 32'h01010101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit req_of(input txn_t t);
    return t.rd | t.wr;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Slave: 16-word memory indexed by address[5:2]; read data appears the cycle after acceptance.
  logic [31:0] mem [16];
  bit          acc_v, acc_wr;
  logic [3:0]  acc_i, acc_be;
  logic [31:0] acc_d;
  int          scnt;
  bit          sprev;

  always @(negedge clk) begin
    acc_v  = (s_read | s_write) && !s_waitrequest;
    acc_wr = s_write;
    acc_i  = s_address[5:2];
    acc_d  = s_writedata;
    acc_be = s_byteenable;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] = mem_init(i);
      s_readdata    = '0;
      s_waitrequest = 1'b0;
      scnt          = 0;
      sprev         = 1'b0;
    end else begin
      if (acc_v) begin
        if (acc_wr) mem[acc_i] = merge(mem[acc_i], acc_d, acc_be);
        else        s_readdata = mem[acc_i];
      end
      if (s_read | s_write) begin
        if (!sprev) scnt = stall_cfg;
        if (rand_stall) s_waitrequest = ($urandom_range(0, 2) == 0);
        else            s_waitrequest = (scnt > 0);
        if (scnt > 0) scnt--;
        sprev = 1'b1;
      end else begin
        s_waitrequest = 1'b0;
        sprev         = 1'b0;
      end
    end
  end

  // Reference model of the arbitration and completion rules, evaluated once per cycle.
  txn_t        snap [2];
  txn_t        cur;
  logic [31:0] ref_mem [16];
  bit          idle_p, done_p, strobe_p, issue_m, last_m, gid_m;
  bit          strobe, rise, expg, done_now, due, low;
  bit          ev [2];
  bit          erd [2];
  int          edue [2];
  logic [31:0] edat [2];
  logic [31:0] lrd [2];
  logic [3:0]  idx;
  int          cyc;

  always @(negedge clk) begin
    if (!run) begin
      idle_p = 1'b1; done_p = 1'b0; strobe_p = 1'b0; issue_m = 1'b0;
      last_m = 1'b1; gid_m = 1'b0; cyc = 0; cur = '0;
      for (int k = 0; k < 2; k++) begin
        snap[k] = '0; ev[k] = 1'b0; erd[k] = 1'b0; edue[k] = 0; edat[k] = '0; lrd[k] = '0;
      end
      for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(i);
    end else begin
      cyc++;
      strobe = s_read | s_write;
      rise   = strobe && !strobe_p;
      expg   = idle_p && (req_of(snap[0]) || req_of(snap[1]));
      if (rise || expg) chk("grant_timing", rise, expg);
      if (rise && expg) begin
        gid_m   = (req_of(snap[0]) && req_of(snap[1])) ? !last_m : req_of(snap[1]);
        last_m  = gid_m;
        cur     = snap[gid_m];
        issue_m = 1'b1;
      end
      chk("grant_id", grant_id, gid_m);
      chk("strobe_active", strobe, issue_m);
      if (issue_m) begin
        chk("s_write", s_write, cur.wr);
        chk("s_read", s_read, !cur.wr);
        chk("s_address", s_address, cur.addr);
        chk("s_byteenable", s_byteenable, cur.be);
        if (cur.wr) chk("s_writedata", s_writedata, cur.data);
        if (!s_waitrequest) begin
          issue_m     = 1'b0;
          ev[gid_m]   = 1'b1;
          edue[gid_m] = cyc + (cur.wr ? 1 : 2);
          erd[gid_m]  = !cur.wr;
          idx         = cur.addr[5:2];
          if (cur.wr) ref_mem[idx] = merge(ref_mem[idx], cur.data, cur.be);
          else        edat[gid_m]  = ref_mem[idx];
        end
      end
      done_now = 1'b0;
      for (int k = 0; k < 2; k++) begin
        due = ev[k] && (edue[k] == cyc);
        low = !wq[k];
        if (low || due) chk($sformatf("completion_m%0d", k), low, due);
        if (due) begin
          ev[k]    = 1'b0;
          done_now = 1'b1;
          if (erd[k]) lrd[k] = edat[k];
        end
        chk($sformatf("readdata_m%0d", k), rdq[k], lrd[k]);
      end
      idle_p   = done_p || (idle_p && !rise);
      done_p   = done_now;
      strobe_p = strobe;
      snap     = tx;
    end
  end

  task automatic do_txn(input int k, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input int lat,
                        input bit mut, output int rdh, output int wrh);
    int n;
    n = 0; rdh = 0; wrh = 0;
    @(posedge clk); #1;
    tx[k] = {rd, wr, a, d, be};
    do begin
      @(negedge clk);
      n++;
      rdh += int'(s_read);
      wrh += int'(s_write);
      if (!wq[k]) break;
      if (mut && n == 3) begin
        #1;
        tx[k].addr = tx[k].addr ^ 32'h0000_0FF0;
        tx[k].data = ~tx[k].data;
      end
    end while (n < 100);
    chk($sformatf("latency_m%0d", k), n, lat);
    @(posedge clk); #1;
    tx[k].rd = 1'b0;
    tx[k].wr = 1'b0;
  endtask

  task automatic rand_master(input int k);
    int n;
    for (int t = 0; t < 25; t++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) begin
        tx[k].rd = 1'b0;
        tx[k].wr = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      tx[k].addr = $urandom;
      tx[k].data = $urandom;
      tx[k].be   = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 2))
        0:       begin tx[k].rd = 1'b1; tx[k].wr = 1'b0; end
        1:       begin tx[k].rd = 1'b0; tx[k].wr = 1'b1; end
        default: begin tx[k].rd = 1'b1; tx[k].wr = 1'b1; end
      endcase
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (wq[k] && n < 100);
      if (wq[k]) chk($sformatf("timeout_m%0d", k), 1, 0);
    end
    @(posedge clk); #1;
    tx[k].rd = 1'b0;
    tx[k].wr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, rh, wh, n, n0, n1;
    rst_n = 1'b0; run = 1'b0; stall_cfg = 0; rand_stall = 1'b0;
    tx[0] = '0; tx[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m0_waitrequest", m0_waitrequest, 1);
    chk("rst_m1_waitrequest", m1_waitrequest, 1);
    chk("rst_strobes", {s_read, s_write}, 0);
    chk("rst_s_fields", {s_address, s_writedata, s_byteenable}, 0);
    chk("rst_readdata", {m0_readdata, m1_readdata}, 0);
    chk("rst_grant_id", grant_id, 0);

    // Both masters reading continuously from reset.
    rst_n = 1'b1; run = 1'b1;
    tx[0] = {1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF};
    tx[1] = {1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'hF};
    c0 = 0; c1 = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (!m0_waitrequest) begin chk("rr_m0_cycle", i, 4 + 8 * c0); c0++; end
      if (!m1_waitrequest) begin chk("rr_m1_cycle", i, 8 + 8 * c1); c1++; end
    end
    chk("rr_m0_count", c0, 4);
    chk("rr_m1_count", c1, 4);
    chk("rr_m0_data", m0_readdata, mem_init(0));
    chk("rr_m1_data", m1_readdata, mem_init(1));
    @(posedge clk); #1;
    tx[0].rd = 1'b0; tx[1].rd = 1'b0;
    repeat (2) @(posedge clk);

    do_txn(0, 1'b0, 1'b1, 32'hBFC0_0030, 32'h0000_000F, 4'b1111, 3, 1'b0, rh, wh);
    chk("wr_s_write_cycles", wh, 1);
    chk("wr_s_read_cycles", rh, 0);

    do_txn(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'b1111, 4, 1'b0, rh, wh);
    chk("rd_s_read_cycles", rh, 1);
    chk("rd_m0_readdata", m0_readdata, 32'h3C08BFC0);

    // Five slave stall cycles with the master moving its inputs mid-stall.
    stall_cfg = 5;
    do_txn(1, 1'b0, 1'b1, 32'h0000_0048, 32'hCAFE_F00D, 4'b0101, 8, 1'b1, rh, wh);
    chk("stall_s_write_cycles", wh, 6);
    stall_cfg = 0;
    do_txn(0, 1'b1, 1'b0, 32'h0000_0048, 32'h0, 4'hF, 4, 1'b0, rh, wh);
    chk("stall_readback", m0_readdata, merge(mem_init(2), 32'hCAFE_F00D, 4'b0101));

    do_txn(1, 1'b1, 1'b1, 32'h0000_0014, 32'h1234_5678, 4'hF, 3, 1'b0, rh, wh);
    chk("both_strobes_reads", rh, 0);
    chk("both_strobes_writes", wh, 1);
    do_txn(1, 1'b1, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 4, 1'b0, rh, wh);
    chk("both_strobes_readback", m1_readdata, 32'h1234_5678);

    // Reset in the middle of a stalled read.
    stall_cfg = 3;
    @(posedge clk); #1;
    tx[0] = {1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'hF};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_read && n < 10);
    chk("reset_issue_reached", s_read, 1);
    #2;
    rst_n = 1'b0; run = 1'b0;
    #1;
    chk("reset_s_read", s_read, 0);
    chk("reset_m0_waitrequest", m0_waitrequest, 1);
    chk("reset_m1_waitrequest", m1_waitrequest, 1);
    chk("reset_grant_id", grant_id, 0);
    tx[0] = '0;
    stall_cfg = 0;
    repeat (2) @(posedge clk);
    #1;
    tx[0] = {1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF};
    tx[1] = {1'b1, 1'b0, 32'h0000_0018, 32'h0, 4'hF};
    rst_n = 1'b1; run = 1'b1;
    n0 = 0; n1 = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!m0_waitrequest && n0 == 0) n0 = i;
      if (!m1_waitrequest && n1 == 0) n1 = i;
    end
    chk("post_reset_m0_first", n0, 4);
    chk("post_reset_m1_second", n1, 8);
    @(posedge clk); #1;
    tx[0] = '0; tx[1] = '0;
    repeat (3) @(posedge clk);

    rand_stall = 1'b1;
    fork
      rand_master(0);
      rand_master(1);
    join
    rand_stall = 1'b0;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
